// File: rtl/treasure_scan_controller.sv
// treasure_scan_controller: settles, majority-votes IMAGE_PROCESSOR frame colours and reports via valid/ack
module treasure_scan_controller #(
    parameter int SETTLE_FRAMES  = 2,
    parameter int VOTE_FRAMES    = 5,
    parameter int TIMEOUT_CYCLES = 2500000,
    parameter int TO_W           = 22
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       VGA_VSYNC_NEG,
    input  logic [5:0] RESULT_IN,
    input  logic       SCAN_REQ,
    output logic       SCAN_BUSY,
    output logic       SCAN_VALID,
    output logic [1:0] SCAN_COLOR,
    input  logic       SCAN_ACK,
    output logic [3:0] VOTES_DONE
);
    localparam int SW = $clog2(SETTLE_FRAMES + 2);
    localparam logic [3:0] HALF = 4'(VOTE_FRAMES / 2);
    typedef enum logic [2:0] {IDLE, SETTLE, VOTE, DECIDE, REPORT} state_t;
    state_t state, state_n;
    logic vsync_prev, fe, is_red, is_blue, settle_done, vote_done, wd_exp;
    logic [SW-1:0] settle_cnt;
    logic [3:0] red_cnt, blue_cnt, null_cnt, votes_done;
    logic [TO_W-1:0] wd;
    logic [1:0] color;
    assign fe          = vsync_prev & ~VGA_VSYNC_NEG;
    assign is_red      = RESULT_IN[5:3] == 3'b001;
    assign is_blue     = RESULT_IN[5:3] == 3'b010;
    assign settle_done = fe && (settle_cnt + 1'b1 == SW'(SETTLE_FRAMES));
    assign vote_done   = fe && (votes_done + 4'd1 == 4'(VOTE_FRAMES));
    assign wd_exp      = wd == TO_W'(TIMEOUT_CYCLES - 1);
    assign SCAN_BUSY   = state inside {SETTLE, VOTE, DECIDE};
    assign SCAN_VALID  = state == REPORT;
    assign SCAN_COLOR  = color;
    assign VOTES_DONE  = votes_done;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = SCAN_REQ ? (SETTLE_FRAMES == 0 ? VOTE : SETTLE) : IDLE;
            SETTLE:  state_n = wd_exp ? REPORT : settle_done ? VOTE : SETTLE;
            VOTE:    state_n = vote_done ? DECIDE : wd_exp ? REPORT : VOTE;
            DECIDE:  state_n = REPORT;
            REPORT:  state_n = SCAN_ACK ? IDLE : REPORT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            vsync_prev <= 1'b0;
            settle_cnt <= '0;
            red_cnt    <= '0;
            blue_cnt   <= '0;
            null_cnt   <= '0;
            votes_done <= '0;
            wd         <= '0;
            color      <= 2'b00;
        end else begin
            state      <= state_n;
            vsync_prev <= VGA_VSYNC_NEG;
            if (state == IDLE && SCAN_REQ) begin
                settle_cnt <= '0;
                red_cnt    <= '0;
                blue_cnt   <= '0;
                null_cnt   <= '0;
                votes_done <= '0;
                wd         <= '0;
            end
            if (state == SETTLE || state == VOTE)
                wd <= wd + 1'b1;
            if (state == SETTLE && fe)
                settle_cnt <= settle_cnt + 1'b1;
            if (state == VOTE && fe) begin
                red_cnt    <= red_cnt + 4'(is_red);
                blue_cnt   <= blue_cnt + 4'(is_blue);
                null_cnt   <= null_cnt + 4'(~is_red & ~is_blue);
                votes_done <= votes_done + 4'd1;
            end
            // entering REPORT from anywhere but DECIDE can only be a watchdog expiry
            if (state == DECIDE)
                color <= red_cnt > HALF ? 2'b01 : blue_cnt > HALF ? 2'b10 : 2'b00;
            else if (state_n == REPORT && state != REPORT)
                color <= 2'b11;
        end
    end
endmodule

// File: tb/tb_treasure_scan_controller.sv
// tb_treasure_scan_controller: directed checks of voting, timeout, handshake and reset behaviour
module tb_treasure_scan_controller;
    localparam logic [5:0] RED = 6'b001000, BLUE = 6'b010000, NUL = 6'b100000, MULTI = 6'b011000;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;
    logic RESET, vsync;
    logic [5:0] result;
    logic req_d, ack_d, req_t, ack_t, req_m, ack_m;
    logic busy_d, valid_d, busy_t, valid_t, busy_m, valid_m;
    logic [1:0] color_d, color_t, color_m;
    logic [3:0] votes_d, votes_t, votes_m;
    int n_checks = 0, n_fail = 0;

    treasure_scan_controller u_def (
        .CLK(CLK), .RESET(RESET), .VGA_VSYNC_NEG(vsync), .RESULT_IN(result),
        .SCAN_REQ(req_d), .SCAN_BUSY(busy_d), .SCAN_VALID(valid_d),
        .SCAN_COLOR(color_d), .SCAN_ACK(ack_d), .VOTES_DONE(votes_d)
    );
    treasure_scan_controller #(.TIMEOUT_CYCLES(100), .TO_W(7)) u_to (
        .CLK(CLK), .RESET(RESET), .VGA_VSYNC_NEG(vsync), .RESULT_IN(result),
        .SCAN_REQ(req_t), .SCAN_BUSY(busy_t), .SCAN_VALID(valid_t),
        .SCAN_COLOR(color_t), .SCAN_ACK(ack_t), .VOTES_DONE(votes_t)
    );
    treasure_scan_controller #(.SETTLE_FRAMES(0), .VOTE_FRAMES(1)) u_min (
        .CLK(CLK), .RESET(RESET), .VGA_VSYNC_NEG(vsync), .RESULT_IN(result),
        .SCAN_REQ(req_m), .SCAN_BUSY(busy_m), .SCAN_VALID(valid_m),
        .SCAN_COLOR(color_m), .SCAN_ACK(ack_m), .VOTES_DONE(votes_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // two high cycles then one low cycle; the falling edge is consumed on the last step
    task automatic frame(input logic [5:0] r);
        result = r;
        vsync = 1'b1;
        step(2);
        vsync = 1'b0;
        step(1);
    endtask

    task automatic scan_d(input logic [5:0] v0, v1, v2, v3, v4, input logic [1:0] exp, input string tag);
        req_d = 1'b1;
        step();
        req_d = 1'b0;
        frame(6'd0); frame(6'd0);
        frame(v0); frame(v1); frame(v2); frame(v3); frame(v4);
        check({tag, " decide"}, valid_d, 0);
        step();
        check({tag, " valid"}, valid_d, 1);
        check({tag, " color"}, color_d, exp);
        ack_d = 1'b1;
        step();
        ack_d = 1'b0;
        check({tag, " ack"}, valid_d, 0);
    endtask

    initial begin
        int n;
        RESET = 1'b1; vsync = 1'b0; result = '0;
        req_d = 0; ack_d = 0; req_t = 0; ack_t = 0; req_m = 0; ack_m = 0;
        step(2);
        check("rst busy", busy_d, 0);
        check("rst valid", valid_d, 0);
        check("rst color", color_d, 0);
        check("rst votes", votes_d, 0);
        RESET = 1'b0;
        step();
        // basic red scan with settle frames
        req_d = 1'b1;
        step();
        req_d = 1'b0;
        check("t1 busy", busy_d, 1);
        frame(RED); frame(RED);
        check("t1 settle ignored", votes_d, 0);
        frame(RED);
        check("t1 first vote", votes_d, 1);
        frame(RED); frame(RED); frame(RED); frame(RED);
        check("t1 decide valid", valid_d, 0);
        check("t1 decide busy", busy_d, 1);
        check("t1 votes", votes_d, 5);
        step();
        check("t1 valid", valid_d, 1);
        check("t1 color", color_d, 2'b01);
        check("t1 report busy", busy_d, 0);
        step();
        check("t1 valid held", valid_d, 1);
        ack_d = 1'b1;
        step();
        ack_d = 1'b0;
        check("t1 ack drop", valid_d, 0);
        check("t1 color kept", color_d, 2'b01);
        scan_d(BLUE, BLUE, RED, BLUE, NUL, 2'b10, "blue maj");
        scan_d(RED, BLUE, NUL, RED, BLUE, 2'b00, "no maj");
        scan_d(MULTI, MULTI, MULTI, MULTI, MULTI, 2'b00, "multihot");
        // request pulse during VOTE must be ignored and not queued
        req_d = 1'b1;
        step();
        req_d = 1'b0;
        frame(6'd0); frame(6'd0); frame(RED);
        req_d = 1'b1;
        step();
        req_d = 1'b0;
        check("req in vote votes", votes_d, 1);
        check("req in vote busy", busy_d, 1);
        frame(RED); frame(RED); frame(RED); frame(RED);
        step();
        check("req in vote valid", valid_d, 1);
        check("req in vote color", color_d, 2'b01);
        ack_d = 1'b1;
        step();
        ack_d = 1'b0;
        step(3);
        check("no queued scan", busy_d, 0);
        // watchdog with VSYNC held high
        vsync = 1'b1;
        step();
        req_t = 1'b1;
        step();
        req_t = 1'b0;
        n = 0;
        while (busy_t && n < 200) begin
            n++;
            step();
        end
        check("to busy cycles", n, 100);
        check("to valid", valid_t, 1);
        check("to color", color_t, 2'b11);
        ack_t = 1'b1;
        step();
        ack_t = 1'b0;
        check("to ack", valid_t, 0);
        // final voting edge lands in the watchdog expiry cycle (cycle 99)
        result = RED;
        req_t = 1'b1;
        step();
        req_t = 1'b0;
        for (int c = 0; c < 100; c++) begin
            vsync = (c >= 39 && c % 10 == 9) ? 1'b0 : 1'b1;
            step();
        end
        check("tie votes", votes_t, 5);
        check("tie decide", valid_t, 0);
        check("tie busy", busy_t, 1);
        step();
        check("tie valid", valid_t, 1);
        check("tie color", color_t, 2'b01);
        ack_t = 1'b1;
        step();
        ack_t = 1'b0;
        // no settle, single vote, ACK already high when VALID rises
        vsync = 1'b1;
        result = RED;
        ack_m = 1'b1;
        req_m = 1'b1;
        step();
        req_m = 1'b0;
        check("min busy", busy_m, 1);
        check("min votes0", votes_m, 0);
        vsync = 1'b0;
        step();
        check("min decide", valid_m, 0);
        step();
        check("min valid", valid_m, 1);
        check("min color", color_m, 2'b01);
        check("min votes", votes_m, 1);
        step();
        check("min one cycle", valid_m, 0);
        ack_m = 1'b0;
        // asynchronous reset in the middle of VOTE
        req_d = 1'b1;
        step();
        req_d = 1'b0;
        frame(6'd0); frame(6'd0); frame(RED); frame(RED);
        check("pre rst votes", votes_d, 2);
        #2 RESET = 1'b1;
        #1;
        check("arst busy", busy_d, 0);
        check("arst valid", valid_d, 0);
        check("arst color", color_d, 0);
        check("arst votes", votes_d, 0);
        step();
        RESET = 1'b0;
        frame(RED); frame(RED); frame(RED); frame(RED); frame(RED);
        step(3);
        check("post rst valid", valid_d, 0);
        check("post rst busy", busy_d, 0);
        // request held across ACK restarts right after IDLE
        req_d = 1'b1;
        step();
        frame(6'd0); frame(6'd0);
        frame(BLUE); frame(BLUE); frame(BLUE); frame(BLUE); frame(BLUE);
        step();
        check("held valid", valid_d, 1);
        check("held color", color_d, 2'b10);
        ack_d = 1'b1;
        step();
        ack_d = 1'b0;
        check("held idle valid", valid_d, 0);
        check("held idle busy", busy_d, 0);
        step();
        check("held rescan busy", busy_d, 1);
        check("held rescan votes", votes_d, 0);
        req_d = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/treasure_scan_controller.md
Name: treasure_scan_controller

Overview:
- Sequences IMAGE_PROCESSOR colour classification for the robot's main FSM.
- On a scan request it discards a programmable number of settling frames, then samples the per-frame RESULT on each VSYNC falling edge and takes a majority vote.
- It reports RED / BLUE / NONE, or TIMEOUT if frames stop arriving, through a valid/ack handshake.
- It sits between IMAGE_PROCESSOR.RESULT and the navigation controller.

Parameters:
- SETTLE_FRAMES, 2: VSYNC falling edges ignored after the request, before voting starts (0 allowed).
- VOTE_FRAMES, 5: frames sampled for the vote (1..15).
- TIMEOUT_CYCLES, 2500000: CLK cycles allowed from request acceptance to the end of voting.
- TO_W, 22: watchdog counter width; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- VGA_VSYNC_NEG  in  1  camera VSYNC, same signal fed to IMAGE_PROCESSOR.
- RESULT_IN  in  6  IMAGE_PROCESSOR.RESULT; bit3 = red, bit4 = blue, bit5 = null; other bits ignored.
- SCAN_REQ  in  1  level request from the navigation FSM.
- SCAN_BUSY  out  1  high in SETTLE, VOTE and DECIDE.
- SCAN_VALID  out  1  SCAN_COLOR is valid; held until acknowledged.
- SCAN_COLOR  out  2  00 none, 01 red, 10 blue, 11 timeout.
- SCAN_ACK  in  1  consumer acknowledge.
- VOTES_DONE  out  4  frames voted so far in the current scan (debug/LED).

Behaviour:
- Reset (async, RESET = 1):
  - State goes to IDLE.
  - All counters = 0; vsync_prev = 0.
  - SCAN_BUSY = 0, SCAN_VALID = 0, SCAN_COLOR = 00, VOTES_DONE = 0.
  - Reset asserted mid-scan aborts with no report.
- Frame edge: fe = vsync_prev & ~VGA_VSYNC_NEG. vsync_prev is registered every cycle. Only fe advances the frame counters. RESULT_IN is sampled in the fe cycle.
- Classification of a sample:
  - bits[5:3] = 001 counts as red.
  - bits[5:3] = 010 counts as blue.
  - Any other pattern (null, zero, multi-hot) counts as null.
- IDLE:
  - SCAN_REQ = 1 moves to SETTLE next cycle, or to VOTE if SETTLE_FRAMES = 0.
  - On that transition, clear red_cnt, blue_cnt, null_cnt, settle_cnt, VOTES_DONE and the watchdog.
- SETTLE:
  - Each fe increments settle_cnt.
  - On the fe that brings settle_cnt to SETTLE_FRAMES, go to VOTE. That edge is not voted.
- VOTE:
  - Each fe increments exactly one of red_cnt, blue_cnt or null_cnt, and increments VOTES_DONE.
  - On the fe that brings VOTES_DONE to VOTE_FRAMES, go to DECIDE.
- DECIDE: one cycle, then REPORT. Latches SCAN_COLOR as follows:
  - 01 if red_cnt > VOTE_FRAMES/2 (integer divide, strict majority).
  - Else 10 if blue_cnt > VOTE_FRAMES/2.
  - Else 00.
- Result latency: SCAN_VALID rises 2 cycles after the final voting fe.
- Watchdog:
  - Counts every cycle in SETTLE and VOTE.
  - On reaching TIMEOUT_CYCLES - 1 it sets SCAN_COLOR = 11 and goes to REPORT, skipping DECIDE.
  - If the watchdog expiry and the final voting fe occur in the same cycle, the vote wins and the next state is DECIDE.
- REPORT:
  - SCAN_VALID = 1 and SCAN_COLOR stable until SCAN_ACK = 1.
  - In the cycle after ACK: SCAN_VALID = 0 and state = IDLE. SCAN_COLOR keeps its last value.
  - ACK outside REPORT is ignored.
- SCAN_REQ handling:
  - Ignored outside IDLE; no queuing.
  - A request still high when IDLE is re-entered starts a new scan in the next cycle.
- VGA_VSYNC_NEG is assumed already synchronous to CLK, as it is in IMAGE_PROCESSOR. No synchroniser is added.

Test Plan:
- Default parameters. Request, then 7 frames with RESULT = 6'b001000. Response: first 2 edges ignored; SCAN_VALID rises 2 cycles after the 7th edge with SCAN_COLOR = 01; VOTES_DONE = 5; ACK then drops VALID next cycle.
- Vote frames blue, blue, red, blue, null. Response: SCAN_COLOR = 10. Frames red, blue, null, red, blue give SCAN_COLOR = 00 (no strict majority).
- RESULT = 6'b011000 (multi-hot) on all frames. Response: counted as null; SCAN_COLOR = 00.
- TIMEOUT_CYCLES = 100. Request with VSYNC held high. Response: SCAN_VALID = 1 with SCAN_COLOR = 11 after 100 busy cycles. Watchdog expiry coinciding with the final fe yields a vote result, not 11.
- SCAN_REQ pulsed during VOTE: no effect. RESET asserted mid-VOTE: all outputs 0 immediately, no VALID afterwards. SCAN_REQ held high across ACK: a new scan starts in the cycle after return to IDLE.
- SETTLE_FRAMES = 0, VOTE_FRAMES = 1. One red frame gives SCAN_COLOR = 01. SCAN_ACK held high at the moment VALID rises: VALID is high for exactly 1 cycle.
